// File: rtl/bicubic_scale_ctrl.sv
// bicubic_scale_ctrl: frame sequencer for the bicubic weight generator.
// Walks the destination raster with fixed-point DDA accumulators, drives the
// blend fractions into the generator and delays the matching integer source
// coordinates so they line up with the generator's weight output. Issue is
// gated by downstream buffer credits because the generator cannot stall.
module bicubic_scale_ctrl #(
   parameter int FRAC_W  = 8,
   parameter int COORD_W = 12,
   parameter int LAT     = 3,
   parameter int CREDITS = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [COORD_W-1:0]        src_w,
   input  logic [COORD_W-1:0]        src_h,
   input  logic [COORD_W-1:0]        dst_w,
   input  logic [COORD_W-1:0]        dst_h,
   input  logic [COORD_W+FRAC_W-1:0] step_x,
   input  logic [COORD_W+FRAC_W-1:0] step_y,
   input  logic [8:0]                cfg_a,
   input  logic                      credit_ret,
   output logic [8:0]                xBlend,
   output logic [8:0]                yBlend,
   output logic [8:0]                bi_a,
   output logic [8:0]                coeffOne,
   output logic [8:0]                coeffHalf,
   output logic                      coef_valid,
   output logic [COORD_W-1:0]        src_x,
   output logic [COORD_W-1:0]        src_y,
   output logic                      line_end,
   output logic                      busy,
   output logic                      done
);

   localparam int ACC_W = COORD_W + FRAC_W;
   localparam int CW    = $clog2(CREDITS + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   // One delay-line entry: the coordinates that belong to one issued blend.
   typedef struct packed {
      logic               vld;
      logic [COORD_W-1:0] ix;
      logic [COORD_W-1:0] iy;
      logic               last;
   } tag_t;

   state_t             state;
   logic [ACC_W-1:0]   acc_x, acc_y;
   logic [ACC_W-1:0]   stx_r, sty_r;
   logic [COORD_W-1:0] dx, dy;
   logic [COORD_W-1:0] sw_m1, sh_m1, dw_m1, dh_m1;
   logic [CW-1:0]      credits;
   // Stage 0 is loaded on the same edge as xBlend/yBlend, so stage LAT is
   // exactly LAT cycles behind the blend outputs.
   tag_t               pipe [LAT:0];

   logic [COORD_W-1:0] ix_raw, iy_raw, ix, iy;
   logic               clamp_x, clamp_y, issue, last_x, last_y, in_flight;

   assign coeffOne  = 9'(1 << FRAC_W);
   assign coeffHalf = 9'(1 << (FRAC_W - 1));

   assign coef_valid = pipe[LAT].vld;
   assign src_x      = pipe[LAT].ix;
   assign src_y      = pipe[LAT].iy;
   assign line_end   = pipe[LAT].last;

   // Integer part, clamp to the source edge, issue qualification.
   always_comb begin
      ix_raw  = acc_x[ACC_W-1:FRAC_W];
      iy_raw  = acc_y[ACC_W-1:FRAC_W];
      clamp_x = ix_raw > sw_m1;
      clamp_y = iy_raw > sh_m1;
      ix      = clamp_x ? sw_m1 : ix_raw;
      iy      = clamp_y ? sh_m1 : iy_raw;
      issue   = (state == RUN) && (credits != '0);
      last_x  = dx == dw_m1;
      last_y  = dy == dh_m1;
   end

   // Anything still travelling through the generator (the final stage is
   // leaving this cycle, so it does not hold up done).
   always_comb begin
      in_flight = 1'b0;
      for (int k = 0; k < LAT; k++) in_flight = in_flight | pipe[k].vld;
   end

   // Frame FSM, raster walk, credit counter and coordinate delay line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc_x   <= '0;
         acc_y   <= '0;
         stx_r   <= '0;
         sty_r   <= '0;
         dx      <= '0;
         dy      <= '0;
         sw_m1   <= '0;
         sh_m1   <= '0;
         dw_m1   <= '0;
         dh_m1   <= '0;
         credits <= CW'(CREDITS);
         xBlend  <= '0;
         yBlend  <= '0;
         bi_a    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int k = 0; k <= LAT; k++) pipe[k] <= '0;
      end else begin
         done <= 1'b0;

         // Issue and return in the same cycle cancel; returns saturate.
         if (issue && !credit_ret)
            credits <= credits - 1'b1;
         else if (!issue && credit_ret && credits != CW'(CREDITS))
            credits <= credits + 1'b1;

         pipe[0] <= issue ? '{vld: 1'b1, ix: ix, iy: iy, last: last_x} : '0;
         for (int k = 1; k <= LAT; k++) pipe[k] <= pipe[k-1];

         case (state)
            IDLE: begin
               if (start) begin
                  sw_m1 <= src_w - 1'b1;
                  sh_m1 <= src_h - 1'b1;
                  dw_m1 <= dst_w - 1'b1;
                  dh_m1 <= dst_h - 1'b1;
                  stx_r <= step_x;
                  sty_r <= step_y;
                  bi_a  <= cfg_a;
                  acc_x <= '0;
                  acc_y <= '0;
                  dx    <= '0;
                  dy    <= '0;
                  busy  <= 1'b1;
                  state <= (dst_w == '0 || dst_h == '0) ? DRAIN : RUN;
               end
            end
            RUN: begin
               if (issue) begin
                  xBlend <= clamp_x ? 9'd0 : 9'(acc_x[FRAC_W-1:0]);
                  yBlend <= clamp_y ? 9'd0 : 9'(acc_y[FRAC_W-1:0]);
                  if (!last_x) begin
                     dx    <= dx + 1'b1;
                     acc_x <= acc_x + stx_r;
                  end else begin
                     dx    <= '0;
                     acc_x <= '0;
                     dy    <= dy + 1'b1;
                     acc_y <= acc_y + sty_r;
                     if (last_y) state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!in_flight) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
